mem_stage: RTL
==============

# mem_stage

Memory/writeback stage directly downstream of the ALU. Captures the ALU result (`out`, `write_rD`, `write_pc`, `memory_mode`) on an enable strobe and performs a single-word memory read or write over a req/ack bus when requested. It then emits a one-cycle writeback pulse to the register file and/or PC. While a memory transaction is outstanding it holds `busy` high so the control unit stalls the pipeline.

## Interface

- `DATA_W`, 16, data and address width (ALU result width)
- `REG_AW`, 3, destination register index width
- `TIMEOUT_CYCLES`, 15, ack watchdog limit (used only with `MEM_TIMEOUT_EN`)

Ports:

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  ALU result valid this cycle; sampled only in IDLE
- `alu_out`  in  DATA_W  ALU result (memory address for READ/WRITE)
- `write_rD`  in  1  ALU requests register writeback
- `write_pc`  in  1  ALU requests PC update
- `memory_mode`  in  2  00 MEM_NOP, 01 MEM_READ, 10 MEM_WRITE, 11 reserved
- `rD_in`  in  REG_AW  destination register index
- `store_data`  in  DATA_W  data for MEM_WRITE
- `mem_req`  out  1  bus request, held until ack
- `mem_we`  out  1  1 = write, valid with `mem_req`
- `mem_addr`  out  DATA_W  bus address
- `mem_wdata`  out  DATA_W  bus write data
- `mem_ack`  in  1  bus completion; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  DATA_W  bus read data
- `busy`  out  1  stage occupied; `enable` ignored
- `done`  out  1  one-cycle writeback strobe
- `reg_we`  out  1  register write (qualified by `done`)
- `reg_waddr`  out  REG_AW  register index
- `reg_wdata`  out  DATA_W  register data
- `pc_we`  out  1  PC write (qualified by `done`)
- `pc_wdata`  out  DATA_W  new PC
- `err`  out  1  one-cycle strobe on timeout (tied 0 without `MEM_TIMEOUT_EN`)

## Operation

- FSM states: IDLE, BUS, WB.
- **IDLE + enable:** latch `alu_out`, `rD_in`, `store_data`, `write_rD`, `write_pc`, `memory_mode`.
  - NOP or reserved mode: go to WB.
  - READ or WRITE mode: go to BUS.
- **BUS:**
  - `mem_req`=1. `mem_addr` = latched `alu_out`. `mem_we`=1 for WRITE, 0 for READ. `mem_wdata` = latched `store_data`.
  - All bus outputs stay stable until `mem_ack` is sampled high.
  - On ack: READ captures `mem_rdata` into `reg_wdata`. Go to WB.
- **WB:** `done`=1 for exactly one cycle, then IDLE.
  - NOP: `reg_we` = `write_rD`, `reg_wdata` = `alu_out`, `pc_we` = `write_pc`, `pc_wdata` = `alu_out`.
  - READ: `reg_we`=1, `pc_we`=0.
  - WRITE: `reg_we`=0, `pc_we`=0.
  - Reserved mode: `reg_we`=0, `pc_we`=0.
- `reg_we` and `pc_we` are forced to 0 whenever `done`=0.
- `busy` = (state ≠ IDLE).
- `enable` while `busy` is dropped. The upstream stall is the caller's responsibility.
- `mem_ack` outside BUS is ignored.
- Widths: no arithmetic. All data passes through unmodified at DATA_W.

## Timing

- All outputs are registered. Reset value of every output is 0; state = IDLE.
- `reset_n` low asynchronously clears all state and outputs, including mid-BUS (`mem_req` drops immediately). No writeback occurs for the aborted operation.
- **NOP latency:**
  - `enable` at edge N.
  - `done` high in cycle N+1 only.
  - `busy` high in cycle N+1 only.
  - Back-to-back `enable` is accepted at edge N+2.
- **READ/WRITE:**
  - `mem_req` high from cycle N+1.
  - Ack sampled at edge M → `mem_req` low and `done` high in cycle M+1.
  - `busy` high from N+1 through M+1.
- Minimum memory op = 3 cycles (ack in first BUS cycle).
- `mem_ack` held high continuously produces one completion only; the FSM leaves BUS.

## Configuration

- **`MEM_TIMEOUT_EN` defined:**
  - A 4-bit-minimum counter, sized to TIMEOUT_CYCLES, clears on BUS entry and increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES, the FSM drops `mem_req`, pulses `err` for one cycle, and returns to IDLE with no `done` and no writeback.
  - Ack on the same edge as expiry wins: normal completion, no `err`.
- **Undefined:** no counter. `err` is constant 0. BUS waits indefinitely.

## Test plan

- **Reset mid-read:** READ to 0x0040, hold `mem_ack`=0, pulse `reset_n` low → `mem_req`, `busy`, `done` all 0 immediately; no `reg_we` afterwards.
- **NOP ALU op:** `alu_out`=0x1234, `write_rD`=1, `rD_in`=5, mode 00 → next cycle `done`=1, `reg_we`=1, `reg_waddr`=5, `reg_wdata`=0x1234, `pc_we`=0.
- **Jump writeback:** `alu_out`=0x00F0, `write_pc`=1, `write_rD`=0, mode 00 → `done`=1, `pc_we`=1, `pc_wdata`=0x00F0, `reg_we`=0.
- **READ with wait states:** `alu_out`=0x0040, `rD_in`=2, ack after 3 wait cycles with `mem_rdata`=0xBEEF.
  - Expect `mem_req`=1, `mem_we`=0, `mem_addr`=0x0040 stable throughout.
  - Expect `done` with `reg_wdata`=0xBEEF, `reg_waddr`=2 in the cycle after ack.
- **WRITE with enable while busy:** `alu_out`=0x0080, `store_data`=0x5A5A, second `enable` asserted while `busy`.
  - Expect `mem_we`=1, `mem_wdata`=0x5A5A.
  - Expect `done` with `reg_we`=0.
  - Expect the second `enable` to be ignored.
- **Timeout (`MEM_TIMEOUT_EN`, TIMEOUT_CYCLES=15):** READ issued, `mem_ack` never asserted → after 15 BUS cycles, `err` pulses 1 cycle, `mem_req`=0, no `done`, `busy`=0.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory/writeback stage with single-word req/ack bus access
//
// Captures an ALU result on enable, optionally performs one bus read or write,
// then issues a one-cycle writeback strobe to the register file and/or PC.
// Optional feature macro: MEM_TIMEOUT_EN (ack watchdog, err strobe on expiry).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   enable                       ALU result valid (sampled only in IDLE)
//   alu_out, write_rD, write_pc  ALU result and writeback requests
//   memory_mode                  00 NOP, 01 READ, 10 WRITE, 11 reserved
//   rD_in, store_data            destination register, data for WRITE
//   mem_req/mem_we/mem_addr/
//   mem_wdata                    bus request side, held stable until ack
//   mem_ack, mem_rdata           bus completion and read data (same cycle)
//   busy                         stage occupied, enable dropped
//   done                         one-cycle writeback strobe
//   reg_we/reg_waddr/reg_wdata   register-file writeback
//   pc_we/pc_wdata               PC writeback
//   err                          one-cycle watchdog expiry strobe
module mem_stage #(
  parameter int DATA_W         = 16,
  parameter int REG_AW         = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              write_rD,
  input  logic              write_pc,
  input  logic [1:0]        memory_mode,
  input  logic [REG_AW-1:0] rD_in,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  state_t state;
  state_t state_nxt;

  // Operation captured at acceptance; held for the whole BUS/WB sequence.
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [REG_AW-1:0] lat_rd;
  logic              lat_wr_rd;
  logic              lat_wr_pc;
  logic [1:0]        lat_mode;

  logic accept;
  assign accept = (state == S_IDLE) && enable;

  // Watchdog: expiry is only raised when ack is absent, so a same-edge ack
  // always takes the normal completion path.
  logic to_expire;
`ifdef MEM_TIMEOUT_EN
  localparam int TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W     = (TO_W_RAW < 4) ? 4 : TO_W_RAW;

  logic [TO_W-1:0] to_cnt;

  assign to_expire = (state == S_BUS) && !mem_ack &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if ((state == S_BUS) && !mem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_expire = 1'b0;
`endif

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable) begin
          if ((memory_mode == MODE_READ) || (memory_mode == MODE_WRITE)) begin
            state_nxt = S_BUS;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_BUS: begin
        if (mem_ack) begin
          state_nxt = S_WB;
        end else if (to_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- operand capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= '0;
      lat_wr_rd <= 1'b0;
      lat_wr_pc <= 1'b0;
      lat_mode  <= MODE_NOP;
    end else if (accept) begin
      lat_addr  <= alu_out;
      lat_wdata <= store_data;
      lat_rd    <= rD_in;
      lat_wr_rd <= write_rD;
      lat_wr_pc <= write_pc;
      lat_mode  <= memory_mode;
    end
  end

  // ---------------------------------------------------------------- output decode
  // Outputs are registered, so they are decoded from the upcoming state and
  // the operand set that will be live in that state (fresh inputs when the
  // operation is being accepted this edge, otherwise the captured copy).
  logic [DATA_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [REG_AW-1:0] op_rd;
  logic              op_wr_rd;
  logic              op_wr_pc;
  logic [1:0]        op_mode;

  logic              mem_req_n;
  logic              mem_we_n;
  logic [DATA_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              busy_n;
  logic              done_n;
  logic              reg_we_n;
  logic [REG_AW-1:0] reg_waddr_n;
  logic [DATA_W-1:0] reg_wdata_n;
  logic              pc_we_n;
  logic [DATA_W-1:0] pc_wdata_n;
  logic              err_n;

  always_comb begin
    op_addr  = accept ? alu_out     : lat_addr;
    op_wdata = accept ? store_data  : lat_wdata;
    op_rd    = accept ? rD_in       : lat_rd;
    op_wr_rd = accept ? write_rD    : lat_wr_rd;
    op_wr_pc = accept ? write_pc    : lat_wr_pc;
    op_mode  = accept ? memory_mode : lat_mode;

    mem_req_n   = (state_nxt == S_BUS);
    mem_we_n    = (state_nxt == S_BUS) && (op_mode == MODE_WRITE);
    mem_addr_n  = (state_nxt == S_BUS) ? op_addr  : '0;
    mem_wdata_n = (state_nxt == S_BUS) ? op_wdata : '0;
    busy_n      = (state_nxt != S_IDLE);
    done_n      = (state_nxt == S_WB);
    err_n       = to_expire;

    // WB never follows WB, so done_n marks the single entry edge into WB.
    reg_we_n = 1'b0;
    pc_we_n  = 1'b0;
    if (done_n) begin
      case (op_mode)
        MODE_NOP: begin
          reg_we_n = op_wr_rd;
          pc_we_n  = op_wr_pc;
        end
        MODE_READ: reg_we_n = 1'b1;
        default: begin
          reg_we_n = 1'b0;
          pc_we_n  = 1'b0;
        end
      endcase
    end

    // Writeback data holds its last value outside WB; only the enables matter.
    reg_waddr_n = reg_waddr;
    reg_wdata_n = reg_wdata;
    pc_wdata_n  = pc_wdata;
    if (done_n) begin
      reg_waddr_n = op_rd;
      // Entering WB in READ mode only happens on the ack edge, so mem_rdata
      // is valid here.
      reg_wdata_n = (op_mode == MODE_READ) ? mem_rdata : op_addr;
      pc_wdata_n  = op_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      pc_we     <= 1'b0;
      pc_wdata  <= '0;
      err       <= 1'b0;
    end else begin
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      busy      <= busy_n;
      done      <= done_n;
      reg_we    <= reg_we_n;
      reg_waddr <= reg_waddr_n;
      reg_wdata <= reg_wdata_n;
      pc_we     <= pc_we_n;
      pc_wdata  <= pc_wdata_n;
      err       <= err_n;
    end
  end

endmodule
